// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard sequencer state encoding, the NOP
// instruction word and the bundle of pipeline-register controls.
package pipe_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_LDUSE  = 2'd1;
    localparam logic [1:0] ST_DWAIT  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_bubble;
        logic id_ie_we;
        logic id_ie_bubble;
        logic ie_im_we;
        logic im_iw_we;
    } ctrl_t;

    // Reset loads NOP into every stage, so enables and bubbles are all set.
    localparam ctrl_t CTRL_RESET  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_FLOW   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/dff.sv
// Generic register cell with synchronous active-high reset to a constant.
module dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/hazard_detect.sv
// Load-use detector: a load in IE whose destination is read by the ID instr.
module hazard_detect (
    input  logic [2:0] ID_rs,
    input  logic [2:0] ID_rt,
    input  logic       ID_rs_vld,
    input  logic       ID_rt_vld,
    input  logic [2:0] IE_writeregsel,
    input  logic       IE_reg_en,
    input  logic       IE_mem_en,
    input  logic       IE_mem_wr,
    output logic       load_use
);

    logic is_load;
    logic rs_hit;
    logic rt_hit;

    assign is_load  = IE_mem_en & ~IE_mem_wr & IE_reg_en;
    assign rs_hit   = ID_rs_vld & (ID_rs == IE_writeregsel);
    assign rt_hit   = ID_rt_vld & (ID_rt == IE_writeregsel);
    assign load_use = is_load & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirects,
// cache-miss stalls and HALT drain, with a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ID_rs,
    input  logic [2:0]       ID_rt,
    input  logic             ID_rs_vld,
    input  logic             ID_rt_vld,
    input  logic [2:0]       IE_writeregsel,
    input  logic             IE_reg_en,
    input  logic             IE_mem_en,
    input  logic             IE_mem_wr,
    input  logic             IE_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             IW_HALT,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_bubble,
    output logic             id_ie_we,
    output logic             id_ie_bubble,
    output logic             ie_im_we,
    output logic             im_iw_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             redirect_pend;
    logic             pend_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_use;
    ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_rs_vld      (ID_rs_vld),
        .ID_rt_vld      (ID_rt_vld),
        .IE_writeregsel (IE_writeregsel),
        .IE_reg_en      (IE_reg_en),
        .IE_mem_en      (IE_mem_en),
        .IE_mem_wr      (IE_mem_wr),
        .load_use       (load_use)
    );

    dff #(.W(2), .RST_VAL(ST_RUN)) u_state (
        .clk (clk), .rst (rst), .d (state_nxt), .q (state)
    );

    dff #(.W(1), .RST_VAL(1'b0)) u_pend (
        .clk (clk), .rst (rst), .d (pend_nxt), .q (redirect_pend)
    );

    dff #(.W(CNT_W), .RST_VAL('0)) u_cnt (
        .clk (clk), .rst (rst), .d (cnt_nxt), .q (cnt_q)
    );

    // DWAIT after the D-cache returns behaves exactly like RUN, and LDUSE
    // differs from RUN only in that the load-use check is suppressed.
    always_comb begin
        ctrl      = CTRL_FLOW;
        state_nxt = state;
        pend_nxt  = redirect_pend;
        if (rst) begin
            ctrl      = CTRL_RESET;
            state_nxt = ST_RUN;
            pend_nxt  = 1'b0;
        end else if (state == ST_HALTED) begin
            ctrl = CTRL_FREEZE;
        end else if (dmem_stall) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = ST_DWAIT;
        end else begin
            state_nxt = ST_RUN;
            if (IE_br_taken) begin
                ctrl.if_id_bubble = 1'b1;
                ctrl.id_ie_bubble = 1'b1;
                ctrl.pc_we        = ~imem_stall;
                if (imem_stall) pend_nxt = 1'b1;
            end else if (load_use && (state != ST_LDUSE)) begin
                ctrl.pc_we        = 1'b0;
                ctrl.if_id_we     = 1'b0;
                ctrl.id_ie_bubble = 1'b1;
                state_nxt         = ST_LDUSE;
            end else if (imem_stall) begin
                ctrl.pc_we        = 1'b0;
                ctrl.if_id_bubble = 1'b1;
            end
            // The fetch in flight belongs to the squashed path; discard it
            // and load the redirect target once the I-cache answers.
            if (redirect_pend) begin
                ctrl.if_id_bubble = 1'b1;
                ctrl.pc_we        = ~imem_stall;
                if (!imem_stall) pend_nxt = 1'b0;
            end
            if (IW_HALT) state_nxt = ST_HALTED;
        end
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (!ctrl.pc_we && (cnt_q != {CNT_W{1'b1}}))
            cnt_nxt = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign pc_we        = ctrl.pc_we;
    assign if_id_we     = ctrl.if_id_we;
    assign if_id_bubble = ctrl.if_id_bubble;
    assign id_ie_we     = ctrl.id_ie_we;
    assign id_ie_bubble = ctrl.id_ie_bubble;
    assign ie_im_we     = ctrl.ie_im_we;
    assign im_iw_we     = ctrl.im_iw_we;
    assign halted       = ~rst & (state == ST_HALTED);
    assign stall_cnt    = cnt_q;

endmodule
